// File: rtl/bike_mul_add_arbiter_if.sv
// Bundle of requester handshakes, result strobes and the multiply-add unit bus
// shared between bike_mul_add_arbiter and whatever sits around it.
interface bike_mul_add_arbiter_if;
  logic        req0_valid;
  logic        req1_valid;
  logic        req0_ready;
  logic        req1_ready;
  logic [24:0] req0_a;
  logic [24:0] req1_a;
  logic [17:0] req0_b;
  logic [17:0] req1_b;
  logic [47:0] req0_c;
  logic [47:0] req1_c;
  logic        res0_valid;
  logic        res1_valid;
  logic [47:0] res_data;
  logic [24:0] mul_a;
  logic [17:0] mul_b;
  logic [47:0] mul_c;
  logic        mul_enable;
  logic        mul_resetn;
  logic [47:0] mul_dout;
  logic        idle;

  // Arbiter side
  modport slave (
    input  req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b, req0_c, req1_c,
    input  mul_dout,
    output req0_ready, req1_ready, res0_valid, res1_valid, res_data,
    output mul_a, mul_b, mul_c, mul_enable, mul_resetn, idle
  );

  // Requesters plus multiply-add unit side
  modport master (
    output req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b, req0_c, req1_c,
    output mul_dout,
    input  req0_ready, req1_ready, res0_valid, res1_valid, res_data,
    input  mul_a, mul_b, mul_c, mul_enable, mul_resetn, idle
  );
endinterface

// File: rtl/bike_mul_add_arbiter.sv
// Two-requester arbiter in front of a LATENCY-deep multiply-add unit, with a tag
// pipeline steering results back. Define BIKE_MULADD_ARB_FIXED_PRIO_EN for fixed req0 priority.
module bike_mul_add_arbiter #(
  parameter int LATENCY = 1
) (
  input logic              clk,
  input logic              reset,
  bike_mul_add_arbiter_if.slave bus
);

  logic               grant_valid;
  logic               grant_id;
  logic [LATENCY:1]   tag_valid_reg;
  logic [LATENCY:1]   tag_id_reg;
  logic               inflight_mid;
  logic               any_tag;

`ifdef BIKE_MULADD_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (!reset) begin
      if (bus.req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (bus.req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end
`else
  logic last_grant_reg;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (!reset) begin
      if (bus.req0_valid && bus.req1_valid) begin
        // Contention goes to whoever was not granted last
        grant_valid = 1'b1;
        grant_id    = ~last_grant_reg;
      end else if (bus.req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (bus.req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= 1'b1;
    end else if (grant_valid) begin
      last_grant_reg <= grant_id;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid_reg <= '0;
      tag_id_reg    <= '0;
    end else begin
      tag_valid_reg[1] <= grant_valid;
      tag_id_reg[1]    <= grant_id;
      for (int i = 2; i <= LATENCY; i++) begin
        tag_valid_reg[i] <= tag_valid_reg[i-1];
        tag_id_reg[i]    <= tag_id_reg[i-1];
      end
    end
  end

  // Operations still travelling through the unit keep it clocked
  genvar gi;
  generate
    if (LATENCY == 1) begin : g_enable_single
      assign inflight_mid = 1'b0;
    end else begin : g_enable_multi
      logic [LATENCY-1:1] mid_any;
      for (gi = 1; gi < LATENCY; gi++) begin : g_mid
        if (gi == 1) begin : g_first
          assign mid_any[gi] = tag_valid_reg[gi];
        end else begin : g_rest
          assign mid_any[gi] = tag_valid_reg[gi] | mid_any[gi-1];
        end
      end
      assign inflight_mid = mid_any[LATENCY-1];
    end
  endgenerate

  assign any_tag = |tag_valid_reg;

  assign bus.req0_ready = grant_valid & ~grant_id;
  assign bus.req1_ready = grant_valid & grant_id;

  assign bus.mul_a = grant_valid ? (grant_id ? bus.req1_a : bus.req0_a) : '0;
  assign bus.mul_b = grant_valid ? (grant_id ? bus.req1_b : bus.req0_b) : '0;
  assign bus.mul_c = grant_valid ? (grant_id ? bus.req1_c : bus.req0_c) : '0;

  // Gating with reset covers the first reset cycle, before the tag flush lands
  assign bus.mul_enable = ~reset & (grant_valid | inflight_mid);
  assign bus.mul_resetn = ~reset;

  assign bus.res0_valid = ~reset & tag_valid_reg[LATENCY] & ~tag_id_reg[LATENCY];
  assign bus.res1_valid = ~reset & tag_valid_reg[LATENCY] &  tag_id_reg[LATENCY];
  assign bus.res_data   = bus.mul_dout;

  assign bus.idle = reset | (~any_tag & ~grant_valid);

endmodule

// File: tb/tb_bike_mul_add_arbiter.sv
// Drives one stimulus stream into LATENCY=1 and LATENCY=3 arbiters, each with a
// behavioural multiply-add unit, and checks them against a grant/result scoreboard.
module tb_bike_mul_add_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v0, v1;
  logic [24:0] a0, a1;
  logic [17:0] b0, b1;
  logic [47:0] c0, c1;

  logic        rdy0 [2];
  logic        rdy1 [2];
  logic        rv0  [2];
  logic        rv1  [2];
  logic        en   [2];
  logic        rstn [2];
  logic        idl  [2];
  logic [47:0] rdata[2];
  logic [24:0] ma   [2];
  logic [17:0] mb   [2];
  logic [47:0] mc   [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [47:0] mac(input logic [24:0] a, input logic [17:0] b,
                                      input logic [47:0] c);
    logic [47:0] ae, be;
    ae = {23'b0, a};
    be = {{30{b[17]}}, b};
    return ae * be + c;
  endfunction

  bike_mul_add_arbiter_if bus [2] ();

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_inst
      localparam int LAT = (gi == 0) ? 1 : 3;
      logic [47:0] p [LAT];

      assign bus[gi].req0_valid = v0;
      assign bus[gi].req1_valid = v1;
      assign bus[gi].req0_a = a0;
      assign bus[gi].req1_a = a1;
      assign bus[gi].req0_b = b0;
      assign bus[gi].req1_b = b1;
      assign bus[gi].req0_c = c0;
      assign bus[gi].req1_c = c1;

      // Reference multiply-add unit: LATENCY registers, clock-enabled, sync active-low reset
      always_ff @(posedge clk) begin
        if (!bus[gi].mul_resetn) begin
          for (int i = 0; i < LAT; i++) p[i] <= '0;
        end else if (bus[gi].mul_enable) begin
          p[0] <= mac(bus[gi].mul_a, bus[gi].mul_b, bus[gi].mul_c);
          for (int i = 1; i < LAT; i++) p[i] <= p[i-1];
        end
      end
      assign bus[gi].mul_dout = p[LAT-1];

      assign rdy0[gi]  = bus[gi].req0_ready;
      assign rdy1[gi]  = bus[gi].req1_ready;
      assign rv0[gi]   = bus[gi].res0_valid;
      assign rv1[gi]   = bus[gi].res1_valid;
      assign en[gi]    = bus[gi].mul_enable;
      assign rstn[gi]  = bus[gi].mul_resetn;
      assign idl[gi]   = bus[gi].idle;
      assign rdata[gi] = bus[gi].res_data;
      assign ma[gi]    = bus[gi].mul_a;
      assign mb[gi]    = bus[gi].mul_b;
      assign mc[gi]    = bus[gi].mul_c;

      bike_mul_add_arbiter #(.LATENCY(LAT)) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus[gi])
      );
    end
  endgenerate

  // Scoreboard: results expected per instance, indexed by due cycle modulo 8
  bit          last_grant;
  bit          ev [2][8];
  bit          eid[2][8];
  logic [47:0] ed [2][8];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic run_cycle(input bit r, input bit q0, input bit q1,
                           input logic [24:0] xa0, input logic [17:0] xb0, input logic [47:0] xc0,
                           input logic [24:0] xa1, input logic [17:0] xb1, input logic [47:0] xc1);
    bit g, gid, e_en, e_idle, busy;
    int slot, lat;
    logic [47:0] e_d;
    @(posedge clk);
    #1;
    rst = r; v0 = q0; v1 = q1;
    a0 = xa0; b0 = xb0; c0 = xc0;
    a1 = xa1; b1 = xb1; c1 = xc1;
    @(negedge clk);

    g = 1'b0;
    gid = 1'b0;
    if (!r) begin
      if (q0 && q1) begin
        g = 1'b1;
`ifdef BIKE_MULADD_ARB_FIXED_PRIO_EN
        gid = 1'b0;
`else
        gid = (last_grant == 1'b1) ? 1'b0 : 1'b1;
`endif
      end else if (q0) begin
        g = 1'b1;
      end else if (q1) begin
        g = 1'b1;
        gid = 1'b1;
      end
    end
    e_d = g ? (gid ? mac(xa1, xb1, xc1) : mac(xa0, xb0, xc0)) : 48'd0;
    slot = cyc % 8;

    for (int k = 0; k < 2; k++) begin
      lat = lat_of(k);
      busy = 1'b0;
      for (int j = 1; j < lat; j++) busy |= ev[k][(cyc + j) % 8];
      e_en = !r && (g || busy);
      busy |= ev[k][slot];
      for (int j = 1; j < lat; j++) busy |= ev[k][(cyc + j) % 8];
      e_idle = r || (!g && !busy);

      check_eq($sformatf("L%0d_ready0", lat), 64'(rdy0[k]), 64'(g && !gid));
      check_eq($sformatf("L%0d_ready1", lat), 64'(rdy1[k]), 64'(g && gid));
      check_eq($sformatf("L%0d_mul_a", lat), 64'(ma[k]), g ? 64'(gid ? xa1 : xa0) : 64'd0);
      check_eq($sformatf("L%0d_mul_b", lat), 64'(mb[k]), g ? 64'(gid ? xb1 : xb0) : 64'd0);
      check_eq($sformatf("L%0d_mul_c", lat), 64'(mc[k]), g ? 64'(gid ? xc1 : xc0) : 64'd0);
      check_eq($sformatf("L%0d_mul_enable", lat), 64'(en[k]), 64'(e_en));
      check_eq($sformatf("L%0d_mul_resetn", lat), 64'(rstn[k]), 64'(!r));
      check_eq($sformatf("L%0d_idle", lat), 64'(idl[k]), 64'(e_idle));
      check_eq($sformatf("L%0d_res0_valid", lat), 64'(rv0[k]), 64'(!r && ev[k][slot] && !eid[k][slot]));
      check_eq($sformatf("L%0d_res1_valid", lat), 64'(rv1[k]), 64'(!r && ev[k][slot] && eid[k][slot]));
      if (!r && ev[k][slot]) begin
        check_eq($sformatf("L%0d_res_data", lat), 64'(rdata[k]), 64'(ed[k][slot]));
      end
    end

    if (r) begin
      for (int k = 0; k < 2; k++)
        for (int s = 0; s < 8; s++) ev[k][s] = 1'b0;
      last_grant = 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        ev[k][slot] = 1'b0;
        if (g) begin
          ev[k][(cyc + lat_of(k)) % 8]  = 1'b1;
          eid[k][(cyc + lat_of(k)) % 8] = gid;
          ed[k][(cyc + lat_of(k)) % 8]  = e_d;
        end
      end
      if (g) begin
        last_grant = gid;
        $display("xfer cyc=%0d req%0d result=%0h", cyc, gid, e_d);
      end
    end
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
    a0 = '0; b0 = '0; c0 = '0; a1 = '0; b1 = '0; c1 = '0;
    last_grant = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < 8; s++) begin
        ev[k][s] = 1'b0; eid[k][s] = 1'b0; ed[k][s] = '0;
      end

    for (int i = 0; i < 3; i++) run_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single request: 3*5+7
    run_cycle(0, 1, 0, 25'd3, 18'd5, 48'd7, 0, 0, 0);
    idle_cycles(4);

    // Contention from a fresh pointer
    run_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      run_cycle(0, 1, 1, 25'd2, 18'd2, 48'd0, 25'd3, 18'd3, 48'd1);
    idle_cycles(4);

    // Negative multiplier wraps modulo 2^48
    run_cycle(0, 0, 1, 0, 0, 0, 25'd1, 18'h3FFFF, 48'd0);
    idle_cycles(4);

    // Reset right after a grant flushes it
    run_cycle(0, 1, 0, 25'd9, 18'd9, 48'd9, 0, 0, 0);
    run_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_cycles(4);

    // Extreme operands back to back
    run_cycle(0, 1, 1, 25'h1FFFFFF, 18'h20000, 48'hFFFF_FFFF_FFFF,
              25'h1FFFFFF, 18'h1FFFF, 48'h8000_0000_0000);
    run_cycle(0, 1, 1, 25'h1FFFFFF, 18'h20000, 48'hFFFF_FFFF_FFFF,
              25'h1FFFFFF, 18'h1FFFF, 48'h8000_0000_0000);
    idle_cycles(4);

    for (int i = 0; i < 500; i++) begin
      run_cycle(($urandom_range(0, 39) == 0),
                ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6),
                25'($urandom), 18'($urandom), {16'($urandom), 32'($urandom)},
                25'($urandom), 18'($urandom), {16'($urandom), 32'($urandom)});
    end
    idle_cycles(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
